map_ram: RTL and testbench
==========================

Name: map_ram

Overview:
- Writable, parametrised map store; successor to the combinational map ROM.
- Serves one registered read channel to the raycaster tracer and one write channel to game/host logic.
- After reset, or on request, a self-initialising sweep FSM writes the outer wall border into every cell.
- Sits between the map editor/host interface and the ray tracer's map lookup.

Parameters:
- ROW_BITS, 4, row address width; ROWS = 2**ROW_BITS; must be >= 2.
- COL_BITS, 4, column address width; COLS = 2**COL_BITS; must be >= 2.
- BITS, 2, bits stored per map cell.
- WALL, all-ones (2'b11 at default BITS), cell value written to border cells by the init sweep.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- init_req  in  1  one-cycle pulse; (re)starts the init sweep.
- ready  out  1  high when the map is initialised and serving requests.
- rd_req  in  1  read request strobe.
- rd_row  in  ROW_BITS  read row address.
- rd_col  in  COL_BITS  read column address.
- rd_valid  out  1  read data valid pulse.
- rd_val  out  BITS  read data.
- wr_en  in  1  write strobe.
- wr_row  in  ROW_BITS  write row address.
- wr_col  in  COL_BITS  write column address.
- wr_val  in  BITS  write data.

Behaviour:
- Reset (async assert, sync release) applies these values:
  - FSM enters INIT; sweep counter is 0.
  - ready=0, rd_valid=0, rd_val=0.
  - Memory contents are not reset; the sweep overwrites them.
- FSM states: INIT, RUN.
- INIT:
  - Each cycle writes one cell at address {row,col} = sweep counter, row-major with col as the low bits.
  - Value written: WALL if row==0, row==ROWS-1, col==0 or col==COLS-1; otherwise 0 (see optional feature).
  - The counter increments each cycle.
  - The cycle that writes the last cell (ROWS-1, COLS-1) transitions to RUN; ready=1 on the next cycle.
  - Sweep length is exactly ROWS*COLS cycles (256 at defaults).
- RUN:
  - ready=1.
  - Asserting init_req sets ready=0 and returns the FSM to INIT with counter 0 on the next cycle.
- init_req during INIT restarts the sweep at counter 0; no cells are skipped or duplicated after a restart.
- Reads:
  - Accepted only when ready=1 and rd_req=1.
  - Latency 1: rd_valid=1 and rd_val = cell[rd_row][rd_col] on the following cycle.
  - rd_valid is 0 in any other cycle; rd_val holds its last value when rd_valid=0.
  - A read issued during INIT, or in the cycle init_req is sampled, is dropped: no rd_valid.
  - Back-to-back reads sustain one result per cycle.
- Writes:
  - Accepted only when ready=1 and init_req=0.
  - Take effect at the clock edge; wr_en in INIT is ignored.
- Same-cycle read and write to the same address: the read returns the OLD value (read-before-write). The new value is visible to a read issued the next cycle.
- Writes may overwrite border cells; the block does not protect the border.
- Address widths are exact powers of two, so there is no out-of-range case.

Optional Feature:
- Macro: MAP_RAM_DUMMY_FILL_EN.
- Defined: during INIT, interior cells with row[1:0]==2'b10 and col[1:0]==2'b10 also receive WALL, giving a pillar grid for bring-up without host writes. Border rule unchanged.
- Undefined: interior cells are written 0.
- Sweep timing and the ready behaviour are identical in both builds.

Test Plan:
- Reset deassert, default parameters: ready=0 for exactly 256 cycles, then 1. Read (0,5), (15,3), (7,0), (4,15) -> rd_val=3. Read (5,5) -> 0, or 3 at (6,6) with MAP_RAM_DUMMY_FILL_EN.
- In RUN, write (3,4)=2'b01, then read (3,4) next cycle -> rd_valid=1, rd_val=1 one cycle after rd_req.
- Same cycle: wr_en to (8,8)=2 and rd_req (8,8) while the cell holds 0 -> rd_val=0. Read (8,8) on the following cycle -> 2.
- Pulse rd_req and wr_en at cycle 10 of INIT -> no rd_valid. After ready, read the written cell -> border/init value, not the write data.
- In RUN, write (5,5)=1, pulse init_req -> ready=0 next cycle for 256 cycles. Afterwards read (5,5) -> 0 (3 with fill macro if pillar rules apply).
- init_req pulsed at sweep cycle 100 -> ready rises 256 cycles after that pulse. Full-map readback matches the init pattern in every cell.

Source files
------------

// File: rtl/map_ram.sv
// -----------------------------------------------------------------------------
// map_ram -- writable map store for the raycaster.
//
// Replaces the old combinational map ROM. One registered read channel serves
// the ray tracer; one write channel serves the map editor / host logic. After
// reset, or on an init_req pulse, a sweep FSM walks every cell once (row-major,
// column in the low address bits) and writes the outer wall border, so the
// host never has to clear the map itself.
//
// Build option:
//   MAP_RAM_DUMMY_FILL_EN - when defined, the sweep also writes WALL into the
//                           interior cells whose row and column both end in
//                           2'b10, producing a pillar grid for bring-up.
//                           Sweep length and ready timing are unchanged.
//
// Ports:
//   clk       in   1         system clock, rising edge
//   reset_n   in   1         asynchronous active-low reset
//   init_req  in   1         one-cycle pulse, (re)starts the init sweep
//   ready     out  1         map initialised and serving requests
//   rd_req    in   1         read request strobe
//   rd_row    in   ROW_BITS  read row address
//   rd_col    in   COL_BITS  read column address
//   rd_valid  out  1         read data valid, one cycle after an accepted read
//   rd_val    out  BITS      read data (holds when rd_valid is low)
//   wr_en     in   1         write strobe
//   wr_row    in   ROW_BITS  write row address
//   wr_col    in   COL_BITS  write column address
//   wr_val    in   BITS      write data
// -----------------------------------------------------------------------------
module map_ram #(
    parameter int              ROW_BITS = 4,
    parameter int              COL_BITS = 4,
    parameter int              BITS     = 2,
    parameter logic [BITS-1:0] WALL     = '1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                init_req,
    output logic                ready,
    input  logic                rd_req,
    input  logic [ROW_BITS-1:0] rd_row,
    input  logic [COL_BITS-1:0] rd_col,
    output logic                rd_valid,
    output logic [BITS-1:0]     rd_val,
    input  logic                wr_en,
    input  logic [ROW_BITS-1:0] wr_row,
    input  logic [COL_BITS-1:0] wr_col,
    input  logic [BITS-1:0]     wr_val
);

    localparam int ADDR_BITS = ROW_BITS + COL_BITS;
    localparam int CELLS     = 1 << ADDR_BITS;

    localparam logic [ROW_BITS-1:0]  ROW_LAST   = '1;
    localparam logic [COL_BITS-1:0]  COL_LAST   = '1;
    localparam logic [ADDR_BITS-1:0] SWEEP_LAST = '1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_reg;
    logic [ADDR_BITS-1:0]   sweep_cnt_reg;
    logic                   ready_reg;
    logic                   rd_valid_reg;
    logic [BITS-1:0]        rd_val_reg;

    // Cell storage; no reset so it maps onto block RAM. The sweep is what
    // gives it defined contents.
    logic [BITS-1:0]        mem [CELLS];

    // ------------------------------------------------------------------
    // Sweep cell value
    // ------------------------------------------------------------------
    logic [ROW_BITS-1:0]    sweep_row;
    logic [COL_BITS-1:0]    sweep_col;
    logic                   sweep_border;
    logic                   sweep_pillar;
    logic [BITS-1:0]        sweep_val;

    assign sweep_row    = sweep_cnt_reg[ADDR_BITS-1:COL_BITS];
    assign sweep_col    = sweep_cnt_reg[COL_BITS-1:0];
    assign sweep_border = (sweep_row == '0) || (sweep_row == ROW_LAST) ||
                          (sweep_col == '0) || (sweep_col == COL_LAST);

`ifdef MAP_RAM_DUMMY_FILL_EN
    // Low two bits of the sweep row/column; a 1-bit address is zero-extended
    // so narrow maps still elaborate (they simply get no pillars).
    logic [1:0] row_lo;
    logic [1:0] col_lo;

    generate
        if (ROW_BITS >= 2) begin : g_row_lo_wide
            assign row_lo = sweep_row[1:0];
        end else begin : g_row_lo_narrow
            assign row_lo = {1'b0, sweep_row[0]};
        end
        if (COL_BITS >= 2) begin : g_col_lo_wide
            assign col_lo = sweep_col[1:0];
        end else begin : g_col_lo_narrow
            assign col_lo = {1'b0, sweep_col[0]};
        end
    endgenerate

    assign sweep_pillar = (row_lo == 2'b10) && (col_lo == 2'b10);
`else
    assign sweep_pillar = 1'b0;
`endif

    assign sweep_val = (sweep_border || sweep_pillar) ? WALL : '0;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    // init_req wins over any host access in the same cycle: the read is
    // dropped and the write is discarded because the map is about to be
    // rebuilt anyway.
    logic rd_accept;
    logic wr_accept;
    logic sweep_we;

    assign rd_accept = ready_reg && rd_req && !init_req;
    assign wr_accept = ready_reg && wr_en  && !init_req;
    // The cycle that samples a restart pulse writes nothing; the next cycle
    // begins again at cell 0, so every cell is written exactly once after
    // the final restart.
    assign sweep_we  = (state_reg == INIT) && !init_req;

    // ------------------------------------------------------------------
    // Single write port, shared by sweep and host
    // ------------------------------------------------------------------
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_waddr;
    logic [BITS-1:0]      mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = sweep_cnt_reg;
        mem_wdata = sweep_val;
        if (sweep_we) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_cnt_reg;
            mem_wdata = sweep_val;
        end else if (wr_accept) begin
            mem_we    = 1'b1;
            mem_waddr = {wr_row, wr_col};
            mem_wdata = wr_val;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Sweep / run FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= INIT;
            sweep_cnt_reg <= '0;
            ready_reg     <= 1'b0;
        end else begin
            case (state_reg)
                INIT: begin
                    if (init_req) begin
                        sweep_cnt_reg <= '0;
                    end else if (sweep_cnt_reg == SWEEP_LAST) begin
                        state_reg     <= RUN;
                        ready_reg     <= 1'b1;
                        sweep_cnt_reg <= '0;
                    end else begin
                        sweep_cnt_reg <= sweep_cnt_reg + ADDR_BITS'(1);
                    end
                end
                RUN: begin
                    if (init_req) begin
                        state_reg     <= INIT;
                        ready_reg     <= 1'b0;
                        sweep_cnt_reg <= '0;
                    end
                end
                default: begin
                    state_reg     <= INIT;
                    ready_reg     <= 1'b0;
                    sweep_cnt_reg <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered read. The array read sees the pre-edge contents, so a
    // same-cycle write to the same cell returns the old value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_reg <= 1'b0;
            rd_val_reg   <= '0;
        end else begin
            rd_valid_reg <= rd_accept;
            if (rd_accept) begin
                rd_val_reg <= mem[{rd_row, rd_col}];
            end
        end
    end

    assign ready    = ready_reg;
    assign rd_valid = rd_valid_reg;
    assign rd_val   = rd_val_reg;

endmodule

// File: tb/tb_map_ram.sv
// -----------------------------------------------------------------------------
// tb_map_ram -- directed self-checking bench for map_ram at default
// parameters (16x16 map, 2-bit cells). Build with or without
// MAP_RAM_DUMMY_FILL_EN; the expected init pattern follows the same macro.
// -----------------------------------------------------------------------------
module tb_map_ram;

    logic       clk;
    logic       reset_n;
    logic       init_req;
    logic       ready;
    logic       rd_req;
    logic [3:0] rd_row;
    logic [3:0] rd_col;
    logic       rd_valid;
    logic [1:0] rd_val;
    logic       wr_en;
    logic [3:0] wr_row;
    logic [3:0] wr_col;
    logic [1:0] wr_val;

    int checks;
    int errors;

    map_ram dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .init_req (init_req),
        .ready    (ready),
        .rd_req   (rd_req),
        .rd_row   (rd_row),
        .rd_col   (rd_col),
        .rd_valid (rd_valid),
        .rd_val   (rd_val),
        .wr_en    (wr_en),
        .wr_row   (wr_row),
        .wr_col   (wr_col),
        .wr_val   (wr_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Value the init sweep must leave in a cell.
    function automatic logic [1:0] exp_init(input int r, input int c);
        if (r == 0 || r == 15 || c == 0 || c == 15) return 2'b11;
`ifdef MAP_RAM_DUMMY_FILL_EN
        if ((r % 4) == 2 && (c % 4) == 2) return 2'b11;
`endif
        return 2'b00;
    endfunction

    // Issue one read and return what appears one cycle later.
    task automatic do_read(input int r, input int c, output logic v, output logic [1:0] d);
        rd_req = 1'b1;
        rd_row = 4'(r);
        rd_col = 4'(c);
        tick();
        v = rd_valid;
        d = rd_val;
        rd_req = 1'b0;
        $display("READ  (%0d,%0d) valid=%0b val=%0d", r, c, v, d);
    endtask

    task automatic do_write(input int r, input int c, input logic [1:0] val);
        wr_en  = 1'b1;
        wr_row = 4'(r);
        wr_col = 4'(c);
        wr_val = val;
        tick();
        wr_en = 1'b0;
        $display("WRITE (%0d,%0d) val=%0d", r, c, val);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        int n;
        reset_n  = 1'b0;
        init_req = 1'b0;
        rd_req   = 1'b0;
        wr_en    = 1'b0;
        rd_row   = '0;
        rd_col   = '0;
        wr_row   = '0;
        wr_col   = '0;
        wr_val   = '0;
        tick();
        tick();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got=%0b want=0", ready);
        end
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd_valid got=%0b want=0", rd_valid);
        end
        checks++;
        if (rd_val !== 2'b00) begin
            errors++;
            $display("FAIL reset_rd_val got=%0d want=0", rd_val);
        end
        reset_n = 1'b1;
        n = 0;
        while (1) begin
            tick();
            n++;
            if (ready === 1'b1 || n > 400) break;
        end
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL reset_sweep_len got=%0d want=256", n);
        end
        $display("RESET sweep cycles=%0d", n);
    endtask

    // ------------------------------------------------------------------
    task automatic test_border();
        int         rr [6] = '{0, 15, 7, 4, 5, 15};
        int         cc [6] = '{5, 3, 0, 15, 5, 15};
        logic [1:0] ee [6] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11};
        logic       v;
        logic [1:0] d;
        for (int i = 0; i < 6; i++) begin
            do_read(rr[i], cc[i], v, d);
            checks++;
            if (v !== 1'b1) begin
                errors++;
                $display("FAIL border_valid (%0d,%0d) got=%0b want=1", rr[i], cc[i], v);
            end
            checks++;
            if (d !== ee[i]) begin
                errors++;
                $display("FAIL border_val (%0d,%0d) got=%0d want=%0d", rr[i], cc[i], d, ee[i]);
            end
        end
        do_read(6, 6, v, d);
        checks++;
`ifdef MAP_RAM_DUMMY_FILL_EN
        if (d !== 2'b11) begin
            errors++;
            $display("FAIL pillar_6_6 got=%0d want=3", d);
        end
`else
        if (d !== 2'b00) begin
            errors++;
            $display("FAIL interior_6_6 got=%0d want=0", d);
        end
`endif
    endtask

    // ------------------------------------------------------------------
    task automatic test_write_read();
        logic       v;
        logic [1:0] d;
        do_write(3, 4, 2'b01);
        do_read(3, 4, v, d);
        checks++;
        if (v !== 1'b1 || d !== 2'b01) begin
            errors++;
            $display("FAIL write_read got valid=%0b val=%0d want valid=1 val=1", v, d);
        end
        // Border cells are writable too.
        do_write(0, 9, 2'b10);
        do_read(0, 9, v, d);
        checks++;
        if (d !== 2'b10) begin
            errors++;
            $display("FAIL border_overwrite got=%0d want=2", d);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_same_cycle();
        logic       v;
        logic [1:0] d;
        wr_en  = 1'b1;
        wr_row = 4'd8;
        wr_col = 4'd8;
        wr_val = 2'b10;
        rd_req = 1'b1;
        rd_row = 4'd8;
        rd_col = 4'd8;
        tick();
        wr_en  = 1'b0;
        rd_req = 1'b0;
        $display("RDWR  (8,8) write=2 valid=%0b val=%0d", rd_valid, rd_val);
        checks++;
        if (rd_valid !== 1'b1 || rd_val !== 2'b00) begin
            errors++;
            $display("FAIL same_cycle_old got valid=%0b val=%0d want valid=1 val=0", rd_valid, rd_val);
        end
        do_read(8, 8, v, d);
        checks++;
        if (d !== 2'b10) begin
            errors++;
            $display("FAIL same_cycle_new got=%0d want=2", d);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        int         rr [3] = '{0, 3, 8};
        int         cc [3] = '{0, 4, 8};
        logic [1:0] ee [3] = '{2'b11, 2'b01, 2'b10};
        for (int i = 0; i < 3; i++) begin
            rd_req = 1'b1;
            rd_row = 4'(rr[i]);
            rd_col = 4'(cc[i]);
            tick();
            $display("B2B   (%0d,%0d) valid=%0b val=%0d", rr[i], cc[i], rd_valid, rd_val);
            checks++;
            if (rd_valid !== 1'b1 || rd_val !== ee[i]) begin
                errors++;
                $display("FAIL b2b_%0d got valid=%0b val=%0d want valid=1 val=%0d", i, rd_valid, rd_val, ee[i]);
            end
        end
        rd_req = 1'b0;
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_val !== 2'b10) begin
            errors++;
            $display("FAIL b2b_idle_hold got valid=%0b val=%0d want valid=0 val=2", rd_valid, rd_val);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_init_req();
        int         n;
        logic       seen_valid;
        logic       v;
        logic [1:0] d;
        do_write(5, 5, 2'b01);
        // init_req with a concurrent read and write: both must be dropped.
        init_req = 1'b1;
        rd_req   = 1'b1;
        rd_row   = 4'd5;
        rd_col   = 4'd5;
        wr_en    = 1'b1;
        wr_row   = 4'd0;
        wr_col   = 4'd0;
        wr_val   = 2'b00;
        tick();
        init_req = 1'b0;
        rd_req   = 1'b0;
        wr_en    = 1'b0;
        $display("INITREQ ready=%0b rd_valid=%0b", ready, rd_valid);
        checks++;
        if (ready !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL init_req_entry got ready=%0b rd_valid=%0b want 0 0", ready, rd_valid);
        end
        seen_valid = 1'b0;
        n = 0;
        while (1) begin
            if (n == 10) begin
                rd_req = 1'b1;
                rd_row = 4'd0;
                rd_col = 4'd5;
                wr_en  = 1'b1;
                wr_row = 4'd0;
                wr_col = 4'd5;
                wr_val = 2'b01;
            end
            tick();
            rd_req = 1'b0;
            wr_en  = 1'b0;
            n++;
            if (rd_valid === 1'b1) seen_valid = 1'b1;
            if (ready === 1'b1 || n > 400) break;
        end
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL reinit_len got=%0d want=256", n);
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++;
            $display("FAIL init_read_dropped got rd_valid=1 want=0");
        end
        do_read(0, 5, v, d);
        checks++;
        if (d !== 2'b11) begin
            errors++;
            $display("FAIL init_write_ignored got=%0d want=3", d);
        end
        do_read(5, 5, v, d);
        checks++;
        if (d !== exp_init(5, 5)) begin
            errors++;
            $display("FAIL reinit_5_5 got=%0d want=%0d", d, exp_init(5, 5));
        end
        do_read(0, 0, v, d);
        checks++;
        if (d !== 2'b11) begin
            errors++;
            $display("FAIL init_req_write_dropped got=%0d want=3", d);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_restart();
        int   n;
        logic low_ok;
        // Scribble over a few cells so the full readback proves the sweep
        // rewrote them.
        do_write(2, 2, 2'b01);
        do_write(15, 15, 2'b00);
        do_write(9, 1, 2'b10);
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        low_ok = 1'b1;
        for (int i = 0; i < 99; i++) begin
            tick();
            if (ready !== 1'b0) low_ok = 1'b0;
        end
        checks++;
        if (low_ok !== 1'b1) begin
            errors++;
            $display("FAIL restart_ready_low got ready=1 during sweep want=0");
        end
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        n = 0;
        while (1) begin
            tick();
            n++;
            if (ready === 1'b1 || n > 400) break;
        end
        $display("RESTART ready after %0d cycles", n);
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL restart_len got=%0d want=256", n);
        end
        // Full-map readback, one read per cycle.
        for (int a = 0; a < 256; a++) begin
            rd_req = 1'b1;
            rd_row = 4'(a / 16);
            rd_col = 4'(a % 16);
            tick();
            $display("READ  (%0d,%0d) valid=%0b val=%0d", a / 16, a % 16, rd_valid, rd_val);
            checks++;
            if (rd_valid !== 1'b1 || rd_val !== exp_init(a / 16, a % 16)) begin
                errors++;
                $display("FAIL readback (%0d,%0d) got valid=%0b val=%0d want valid=1 val=%0d",
                         a / 16, a % 16, rd_valid, rd_val, exp_init(a / 16, a % 16));
            end
        end
        rd_req = 1'b0;
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_val !== 2'b11) begin
            errors++;
            $display("FAIL readback_tail got valid=%0b val=%0d want valid=0 val=3", rd_valid, rd_val);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_border();
        test_write_read();
        test_same_cycle();
        test_back_to_back();
        test_init_req();
        test_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
